// File: rtl/upsample_nearest_layer_if.sv
// Stream bundle for the nearest-neighbour upsampler: pixel input side,
// upsampled output side and the frame-end marker.
interface upsample_nearest_layer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         ready_in;
  logic                         ready_out;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         last_out;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, last_out
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, last_out
  );
endinterface

// File: rtl/upsample_nearest_layer.sv
// Streaming nearest-neighbour upsampler: each input pixel is repeated SCALE
// times per row and each row SCALE times, through one registered output slot.
//
// state     | meaning
// ST_LOAD   | first copy of an input row; pixels taken from data_in / hold reg
// ST_REPLAY | repeat copies of the row, read back from the line buffer
module upsample_nearest_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = 7,
  parameter int IN_HEIGHT  = 7,
  parameter int SCALE      = 2
) (
  input logic                     clk,
  input logic                     rst,
  upsample_nearest_layer_if.slave bus
);

  localparam int XW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int YW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int SW = $clog2(SCALE);

  localparam logic [XW-1:0] X_MAX = XW'(IN_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IN_HEIGHT - 1);
  localparam logic [SW-1:0] S_MAX = SW'(SCALE - 1);
  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam logic [SW-1:0] S_ONE = SW'(1);

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_REPLAY = 1'b1;

  logic signed [DATA_WIDTH-1:0] r_buf [IN_WIDTH];
  logic signed [DATA_WIDTH-1:0] r_hold;
  logic signed [DATA_WIDTH-1:0] r_data;
  logic                         r_valid;
  logic                         r_last;
  logic [0:0]                   r_state;
  logic [XW-1:0]                r_in_x;
  logic [YW-1:0]                r_in_y;
  logic [SW-1:0]                r_col;
  logic [SW-1:0]                r_row;

  logic                         w_slot_free;
  logic                         w_new_px;
  logic                         w_load;
  logic                         w_col_end;
  logic                         w_x_end;
  logic                         w_row_end;
  logic                         w_y_end;
  logic                         w_frame_end;
  logic signed [DATA_WIDTH-1:0] w_load_data;

  assign w_slot_free = !r_valid || bus.ready_out;
  assign w_new_px    = (r_state == ST_LOAD) && (r_col == '0);
  assign w_load      = w_slot_free && (w_new_px ? bus.valid_in : 1'b1);

  assign w_col_end   = (r_col  == S_MAX);
  assign w_x_end     = (r_in_x == X_MAX);
  assign w_row_end   = (r_row  == S_MAX);
  assign w_y_end     = (r_in_y == Y_MAX);
  assign w_frame_end = w_col_end && w_x_end && w_row_end && w_y_end;

  // Combinational line-buffer read keeps REPLAY rows bubble-free.
  always_comb begin
    w_load_data = r_hold;
    if (w_new_px) begin
      w_load_data = bus.data_in;
    end else if (r_state == ST_REPLAY) begin
      w_load_data = r_buf[r_in_x];
    end
  end

  always_ff @(posedge clk) begin
    if (w_load && w_new_px) begin
      r_buf[r_in_x] <= bus.data_in;
      r_hold        <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_state <= ST_LOAD;
      r_in_x  <= '0;
      r_in_y  <= '0;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_load) begin
      r_data  <= w_load_data;
      r_valid <= 1'b1;
      r_last  <= w_frame_end;
      if (w_col_end) begin
        r_col <= '0;
        if (w_x_end) begin
          r_in_x <= '0;
          if (w_row_end) begin
            r_row   <= '0;
            r_state <= ST_LOAD;
            r_in_y  <= w_y_end ? '0 : r_in_y + Y_ONE;
          end else begin
            r_row   <= r_row + S_ONE;
            r_state <= ST_REPLAY;
          end
        end else begin
          r_in_x <= r_in_x + X_ONE;
        end
      end else begin
        r_col <= r_col + S_ONE;
      end
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign bus.ready_in  = w_slot_free && w_new_px;
  assign bus.valid_out = r_valid;
  assign bus.data_out  = r_data;
  assign bus.last_out  = r_last;

endmodule
